// File: rtl/find_pkg.sv
// Shared helpers for the pipelined minimum/maximum finder.
// Provides tree level and padded leaf counts for a given entry count.
package find_pkg;

    // Number of reduction levels (one pipeline stage per level).
    function automatic int lvl_cnt(input int n);
        return $clog2(n);
    endfunction

    // Leaf count of the tree, rounded up to a power of two.
    function automatic int pad_cnt(input int n);
        return 1 << $clog2(n);
    endfunction

endpackage

// File: rtl/find_node.sv
// Combinational 2-input compare/select cell of the reduction tree.
// Ports: i_max selects max instead of min; i_a_* / i_b_* are the
// {inc, value, idx} children; o_* is the surviving node.
module find_node #(
    parameter int W     = 7,
    parameter int IDX_W = 5
) (
    input  logic             i_max,
    input  logic             i_a_inc,
    input  logic [W-1:0]     i_a_val,
    input  logic [IDX_W-1:0] i_a_idx,
    input  logic             i_b_inc,
    input  logic [W-1:0]     i_b_val,
    input  logic [IDX_W-1:0] i_b_idx,
    output logic             o_inc,
    output logic [W-1:0]     o_val,
    output logic [IDX_W-1:0] o_idx
);

    logic w_tie;
    logic w_b_wins;
    logic w_pick_b;

    assign w_tie    = (i_a_val == i_b_val);
    assign w_b_wins = i_max ? (i_b_val > i_a_val) : (i_b_val < i_a_val);
    // Equal values resolve to the lower index.
    assign w_pick_b = w_b_wins || (w_tie && (i_b_idx < i_a_idx));

    always_comb begin
        o_inc = 1'b0;
        o_val = '0;
        o_idx = '0;
        unique case (1'b1)
            (i_a_inc && i_b_inc): begin
                o_inc = 1'b1;
                o_val = w_pick_b ? i_b_val : i_a_val;
                o_idx = w_pick_b ? i_b_idx : i_a_idx;
            end
            (i_a_inc && !i_b_inc): begin
                o_inc = 1'b1;
                o_val = i_a_val;
                o_idx = i_a_idx;
            end
            (!i_a_inc && i_b_inc): begin
                o_inc = 1'b1;
                o_val = i_b_val;
                o_idx = i_b_idx;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/find_smallest_pipe.sv
// Pipelined argmin over N masked W-bit values, one frame per cycle.
// Ports: valid/ready in (num, mask), valid/ready out (smallest,
// smallest_idx, none_valid). FIND_SMALLEST_MAXMODE_EN adds mode_max.
module find_smallest_pipe
    import find_pkg::*;
#(
    parameter int N     = 32,
    parameter int W     = 7,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   num,
    input  logic [N-1:0]     mask,
`ifdef FIND_SMALLEST_MAXMODE_EN
    input  logic             mode_max,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     smallest,
    output logic [IDX_W-1:0] smallest_idx,
    output logic             none_valid
);

    localparam int L = lvl_cnt(N);
    localparam int P = pad_cnt(N);

    typedef struct packed {
        logic             inc;
        logic [W-1:0]     value;
        logic [IDX_W-1:0] idx;
    } node_t;

    // Heap layout: node j has children 2j and 2j+1; leaves are P..2P-1.
    node_t      w_kid [2:2*P-1];
    logic [L-1:0] r_vld;
    logic [L-1:0] w_mode;
    logic         w_en;

    assign w_en      = !(r_vld[L-1] && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_vld[L-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld[0] <= in_valid;
            for (int s = 1; s < L; s++) begin
                r_vld[s] <= r_vld[s-1];
            end
        end
    end

    // w_mode[s] is the mode of the frame held in stage s (0 = input).
`ifdef FIND_SMALLEST_MAXMODE_EN
    assign w_mode[0] = mode_max;
    for (genvar s = 1; s < L; s++) begin : g_mode
        logic r_mode;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mode <= 1'b0;
            end else if (w_en) begin
                r_mode <= w_mode[s-1];
            end
        end
        assign w_mode[s] = r_mode;
    end
`else
    assign w_mode = '0;
`endif

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N) begin : g_real
            assign w_kid[P+i] = '{
                inc:   mask[i],
                value: num[i*W +: W],
                idx:   IDX_W'(i)
            };
        end else begin : g_pad
            assign w_kid[P+i] = '0;
        end
    end

    for (genvar lv = 0; lv < L; lv++) begin : g_lvl
        for (genvar k = 0; k < (1 << lv); k++) begin : g_nd
            localparam int J = (1 << lv) + k;

            logic             w_inc;
            logic [W-1:0]     w_val;
            logic [IDX_W-1:0] w_idx;

            find_node #(
                .W     (W),
                .IDX_W (IDX_W)
            ) u_node (
                .i_max   (w_mode[L-1-lv]),
                .i_a_inc (w_kid[2*J].inc),
                .i_a_val (w_kid[2*J].value),
                .i_a_idx (w_kid[2*J].idx),
                .i_b_inc (w_kid[2*J+1].inc),
                .i_b_val (w_kid[2*J+1].value),
                .i_b_idx (w_kid[2*J+1].idx),
                .o_inc   (w_inc),
                .o_val   (w_val),
                .o_idx   (w_idx)
            );

            if (J == 1) begin : g_root
                // Root keeps an explicit none flag so reset reads 0.
                logic             r_none;
                logic [W-1:0]     r_val;
                logic [IDX_W-1:0] r_idx;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_none <= 1'b0;
                        r_val  <= '0;
                        r_idx  <= '0;
                    end else if (w_en) begin
                        r_none <= !w_inc;
                        r_val  <= w_val;
                        r_idx  <= w_idx;
                    end
                end
                assign none_valid   = r_none;
                assign smallest     = r_val;
                assign smallest_idx = r_idx;
            end else begin : g_int
                node_t r_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_en) begin
                        r_q <= '{inc: w_inc, value: w_val, idx: w_idx};
                    end
                end
                assign w_kid[J] = r_q;
            end
        end
    end

endmodule

// File: tb/tb_find_smallest_pipe.sv
// Bench for find_smallest_pipe: directed frames, random stream with
// back-pressure and a queue scoreboard, mid-stream reset, N=5 instance.
module tb_find_smallest_pipe;

    localparam int N = 32;
    localparam int W = 7;
    localparam int L = 5;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] num;
    logic [N-1:0]   mask;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   smallest;
    logic [4:0]     smallest_idx;
    logic           none_valid;

    logic           in_valid5;
    logic           in_ready5;
    logic [5*W-1:0] num5;
    logic [4:0]     mask5;
    logic           out_valid5;
    logic [W-1:0]   smallest5;
    logic [2:0]     smallest_idx5;
    logic           none_valid5;
`ifdef FIND_SMALLEST_MAXMODE_EN
    logic           mode_max;
    logic           mode_max5;
`endif

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    typedef struct {
        logic [W-1:0] v;
        logic [4:0]   i;
        logic         n;
    } exp_t;

    exp_t sb[$];

    logic           p_stall = 1'b0;
    logic [W-1:0]   p_val;
    logic [4:0]     p_idx;
    logic           p_none;

    find_smallest_pipe #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .num          (num),
        .mask         (mask),
`ifdef FIND_SMALLEST_MAXMODE_EN
        .mode_max     (mode_max),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .smallest     (smallest),
        .smallest_idx (smallest_idx),
        .none_valid   (none_valid)
    );

    find_smallest_pipe #(.N(5), .W(W)) dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid5),
        .in_ready     (in_ready5),
        .num          (num5),
        .mask         (mask5),
`ifdef FIND_SMALLEST_MAXMODE_EN
        .mode_max     (mode_max5),
`endif
        .out_valid    (out_valid5),
        .out_ready    (1'b1),
        .smallest     (smallest5),
        .smallest_idx (smallest_idx5),
        .none_valid   (none_valid5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N*W-1:0] n,
                                   input logic [N-1:0] m);
        exp_t e;
        e.v = '0;
        e.i = '0;
        e.n = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (m[k] && (e.n || n[k*W +: W] < e.v)) begin
                e.v = n[k*W +: W];
                e.i = 5'(k);
                e.n = 1'b0;
            end
        end
        return e;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            p_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 32'(in_ready),
                32'(!(out_valid && !out_ready)));
            if (p_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_val", 32'(smallest), 32'(p_val));
                chk("stall_idx", 32'(smallest_idx), 32'(p_idx));
                chk("stall_none", 32'(none_valid), 32'(p_none));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_val", 32'(smallest), 32'(e.v));
                    chk("sb_idx", 32'(smallest_idx), 32'(e.i));
                    chk("sb_none", 32'(none_valid), 32'(e.n));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(num, mask));
                n_acc++;
            end
            p_stall = out_valid && !out_ready;
            p_val   = smallest;
            p_idx   = smallest_idx;
            p_none  = none_valid;
        end
    end

    task automatic send(input logic [N*W-1:0] fn, input logic [N-1:0] fm);
        @(posedge clk);
        #1;
        num      = fn;
        mask     = fm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (L-2) @(posedge clk);
        #1;
        chk("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
    endtask

    logic [N*W-1:0] f_up, f_tie, f_msk;
    int base;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        num       = '0;
        mask      = '0;
        in_valid5 = 1'b0;
        num5      = '0;
        mask5     = '0;
`ifdef FIND_SMALLEST_MAXMODE_EN
        mode_max  = 1'b0;
        mode_max5 = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            f_up[i*W +: W]  = 7'(100 - i);
            f_tie[i*W +: W] = 7'd20;
            f_msk[i*W +: W] = 7'd50;
        end
        f_tie[7*W +: W]  = 7'd3;
        f_tie[19*W +: W] = 7'd3;
        f_msk[4*W +: W]  = 7'd0;
        f_msk[12*W +: W] = 7'd9;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_smallest", 32'(smallest), 32'd0);
        chk("rst_idx", 32'(smallest_idx), 32'd0);
        chk("rst_none", 32'(none_valid), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(f_up, '1);
        chk("desc_val", 32'(smallest), 32'd69);
        chk("desc_idx", 32'(smallest_idx), 32'd31);
        chk("desc_none", 32'(none_valid), 32'd0);

        send(f_tie, '1);
        chk("tie_val", 32'(smallest), 32'd3);
        chk("tie_idx", 32'(smallest_idx), 32'd7);

        send(f_msk, ~(32'd1 << 4));
        chk("mask_val", 32'(smallest), 32'd9);
        chk("mask_idx", 32'(smallest_idx), 32'd12);
        chk("mask_none", 32'(none_valid), 32'd0);

        send(f_msk, '0);
        chk("none_flag", 32'(none_valid), 32'd1);
        chk("none_val", 32'(smallest), 32'd0);
        chk("none_idx", 32'(smallest_idx), 32'd0);

        send('1, '1);
        chk("max_val", 32'(smallest), 32'd127);
        chk("max_idx", 32'(smallest_idx), 32'd0);

        // Random stream with random back-pressure.
        base = n_acc;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (n_acc - base >= 40) break;
            for (int i = 0; i < N; i++) begin
                num[i*W +: W] = 7'($urandom_range(0, 127));
            end
            mask = ($urandom_range(0, 7) == 0) ? '0 : 32'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
        end
        in_valid = 1'b0;
        chk("rand_accepts", 32'(n_acc - base), 32'd40);
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        chk("drain_idle", 32'(out_valid), 32'd0);

        // Reset while three frames are in flight.
        @(posedge clk);
        #1;
        num      = f_up;
        mask     = '1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        num = f_tie;
        @(posedge clk);
        #1;
        num = f_msk;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_val", 32'(smallest), 32'd0);
        chk("async_rst_none", 32'(none_valid), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        send(f_tie, '1);
        chk("post_rst_val", 32'(smallest), 32'd3);
        chk("post_rst_idx", 32'(smallest_idx), 32'd7);

        // Non-power-of-two instance, three levels.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) num5[i*W +: W] = 7'(9 - i);
        mask5     = '1;
        in_valid5 = 1'b1;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        @(posedge clk);
        #1;
        chk("n5_lat_early", 32'(out_valid5), 32'd0);
        @(posedge clk);
        #1;
        chk("n5_valid", 32'(out_valid5), 32'd1);
        chk("n5_val", 32'(smallest5), 32'd5);
        chk("n5_idx", 32'(smallest_idx5), 32'd4);
        chk("n5_none", 32'(none_valid5), 32'd0);
        chk("n5_ready", 32'(in_ready5), 32'd1);
`ifdef FIND_SMALLEST_MAXMODE_EN
        mode_max5 = 1'b1;
        in_valid5 = 1'b1;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        mode_max5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("n5_max_valid", 32'(out_valid5), 32'd1);
        chk("n5_max_val", 32'(smallest5), 32'd9);
        chk("n5_max_idx", 32'(smallest_idx5), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
